// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2
  } state_t;

  localparam int MASK_W = 32;

  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Low len bits set; patterns are limited to MASK_W bits.
  function automatic logic [MASK_W-1:0] mask(input int unsigned len);
    if (len >= MASK_W) return '1;
    return (MASK_W'(1) << len) - MASK_W'(1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial detector for a runtime-programmable bit pattern with overlap control
// and a saturating match counter.
//
// state | meaning
// IDLE  | en low; history and fill cleared
// FILL  | collecting the first len-1 bits of a fresh window
// ARMED | every accepted bit is compared against the pattern
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 16,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'b0000_0011,
  parameter int                 RST_LEN     = 2,
  localparam int                LEN_W       = len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err,
  output logic               busy
);

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               match_d, cfg_err_d;

  logic [MASK_W-1:0]  mask_w;
  logic [MAX_LEN-1:0] hist_shift;
  logic [LEN_W-1:0]   fill_eff;
  logic               cfg_ok, accept, hit, window_full;

  assign mask_w      = mask(32'(len_q));
  assign hist_shift  = {hist_q[MAX_LEN-2:0], in_bit};
  assign hit         = ((hist_shift ^ pattern_q) & mask_w[MAX_LEN-1:0]) == '0;
  assign cfg_ok      = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  assign accept      = in_valid & en & ~cfg_we;
  // Entering from IDLE counts as a fresh window, so the first bit is fill 0.
  assign fill_eff    = (state_q == IDLE) ? '0 : fill_q;
  assign window_full = (state_q == ARMED) || (fill_eff == len_q - LEN_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pattern_q <= RST_PATTERN;
      len_q     <= LEN_W'(RST_LEN);
      overlap_q <= 1'b1;
      hist_q    <= '0;
      fill_q    <= '0;
      match     <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      match     <= match_d;
      cfg_err   <= cfg_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    match_d   = 1'b0;
    cfg_err_d = 1'b0;
    if (cfg_we && cfg_ok) begin
      pattern_d = cfg_pattern;
      len_d     = cfg_len;
      overlap_d = cfg_overlap;
      hist_d    = '0;
      fill_d    = '0;
      state_d   = en ? FILL : IDLE;
    end else begin
      cfg_err_d = cfg_we;
      if (!en) begin
        state_d = IDLE;
        hist_d  = '0;
        fill_d  = '0;
      end else begin
        if (state_q == IDLE) begin
          state_d = FILL;
          fill_d  = '0;
        end
        if (accept) begin
          hist_d = hist_shift;
          if (window_full) begin
            match_d = hit;
            if (hit && !overlap_q) begin
              state_d = FILL;
              fill_d  = '0;
            end else begin
              state_d = ARMED;
            end
          end else begin
            state_d = FILL;
            fill_d  = fill_eff + LEN_W'(1);
          end
        end
      end
    end
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (match_d),
    .clr  (cnt_clr),
    .q    (match_cnt)
  );

endmodule
